hazard_fwd_unit: RTL and testbench

Control-side counterpart of the execute-stage ALU. It produces the ALU operand selects (Asel/Bsel) and the store/branch rs2 forwarding select for each instruction entering X. It tracks destination registers through X/M/W in shadow pipeline registers, detects load-use hazards and stalls decode. It honours taken-branch/jump flushes resolved in X.

---
 rtl/hazard_fwd_unit.sv | 139 +++++++++++++
 tb/tb_hazard_fwd_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding control for the execute stage: ALU operand selects, rs2 forwarding,
// load-use stall and flush handling, tracked through X/M/W shadow entries.
module hazard_fwd_unit #(
   parameter int unsigned REG_AW            = 5,
   parameter int unsigned LOAD_STALL_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       inst_d,
   input  logic              valid_d,
   input  logic              flush_x,
   output logic              stall_d,
   output logic [1:0]        asel_x,
   output logic [1:0]        bsel_x,
   output logic [1:0]        rs2sel_x,
   output logic [REG_AW-1:0] rd_w,
   output logic              regwen_w
);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_IALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [1:0] SEL_REG = 2'b00;
   localparam logic [1:0] SEL_ALT = 2'b01;
   localparam logic [1:0] SEL_M   = 2'b10;
   localparam logic [1:0] SEL_W   = 2'b11;

   if (LOAD_STALL_CYCLES != 1) begin : g_param_chk
      $error("hazard_fwd_unit: only LOAD_STALL_CYCLES == 1 is supported");
   end

   typedef struct packed {
      logic              valid;
      logic              wr;
      logic              ld;
      logic [REG_AW-1:0] rd;
   } ent_t;

   ent_t             r_x, r_m, r_w;
   logic [1:0]       r_asel, r_bsel, r_rs2sel;

   logic [6:0]        w_opc;
   logic [REG_AW-1:0] w_rd, w_rs1, w_rs2;
   logic              w_r, w_i, w_ld, w_st, w_br, w_jalr, w_jal, w_lui, w_auipc;
   logic              w_use1, w_use2, w_wr, w_stall, w_bubble;
   logic [1:0]        w_base_a, w_base_b, w_a, w_b, w_r2;
   ent_t              w_x_nxt;
   logic              w_unused;

   assign w_unused = ^inst_d[31:25];

   // Youngest matching producer wins: X entry (ends up in M) over M entry (ends up in W).
   function automatic logic [1:0] fwd(input logic use_r, input logic [REG_AW-1:0] rs,
                                      input ent_t x, input ent_t m);
      logic [1:0] sel;
      sel = SEL_REG;
      if (use_r && rs != '0) begin
         if (x.valid && x.wr && x.rd == rs)      sel = SEL_M;
         else if (m.valid && m.wr && m.rd == rs) sel = SEL_W;
      end
      return sel;
   endfunction

   always_comb begin
      w_opc   = inst_d[6:0];
      w_rd    = REG_AW'(inst_d[11:7]);
      w_rs1   = REG_AW'(inst_d[19:15]);
      w_rs2   = REG_AW'(inst_d[24:20]);
      w_r     = (w_opc == OP_R);
      w_i     = (w_opc == OP_IALU);
      w_ld    = (w_opc == OP_LOAD);
      w_st    = (w_opc == OP_STORE);
      w_br    = (w_opc == OP_BR);
      w_jalr  = (w_opc == OP_JALR);
      w_jal   = (w_opc == OP_JAL);
      w_lui   = (w_opc == OP_LUI);
      w_auipc = (w_opc == OP_AUIPC);

      w_use1 = valid_d && (w_r || w_i || w_ld || w_st || w_br || w_jalr);
      w_use2 = valid_d && (w_r || w_st || w_br);
      w_wr   = valid_d && (w_r || w_i || w_ld || w_lui || w_auipc || w_jal || w_jalr)
               && (w_rd != '0);

      w_base_a = (w_auipc || w_jal || w_br) ? SEL_ALT : SEL_REG;
      w_base_b = (w_i || w_ld || w_st || w_br || w_jalr || w_jal || w_lui || w_auipc)
                 ? SEL_ALT : SEL_REG;

      w_a  = (w_base_a == SEL_REG) ? fwd(w_use1, w_rs1, r_x, r_m) : w_base_a;
      w_b  = (w_base_b == SEL_REG) ? fwd(w_use2, w_rs2, r_x, r_m) : w_base_b;
      w_r2 = (w_st || w_br) ? fwd(w_use2, w_rs2, r_x, r_m) : SEL_REG;

      // Flush wins over the load-use stall: the D instruction is wrong-path anyway.
      w_stall = r_x.valid && r_x.ld && (r_x.rd != '0) && !flush_x &&
                ((w_use1 && w_rs1 == r_x.rd) || (w_use2 && w_rs2 == r_x.rd));
      w_bubble = w_stall || flush_x || !valid_d;

      w_x_nxt = '0;
      if (!w_bubble) begin
         w_x_nxt.valid = 1'b1;
         w_x_nxt.wr    = w_wr;
         w_x_nxt.ld    = w_ld;
         w_x_nxt.rd    = w_wr ? w_rd : '0;
      end
   end

   // Shadow pipeline and registered X-stage selects.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x      <= '0;
         r_m      <= '0;
         r_w      <= '0;
         r_asel   <= SEL_REG;
         r_bsel   <= SEL_REG;
         r_rs2sel <= SEL_REG;
      end else begin
         r_x      <= w_x_nxt;
         r_m      <= r_x;
         r_w      <= r_m;
         r_asel   <= w_bubble ? SEL_REG : w_a;
         r_bsel   <= w_bubble ? SEL_REG : w_b;
         r_rs2sel <= w_bubble ? SEL_REG : w_r2;
      end
   end

   assign stall_d  = w_stall;
   assign asel_x   = r_asel;
   assign bsel_x   = r_bsel;
   assign rs2sel_x = r_rs2sel;
   assign rd_w     = r_w.rd;
   assign regwen_w = r_w.valid && r_w.wr;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed vector bench for hazard_fwd_unit: one table row per D-stage cycle,
// plus a hand-written mid-stream reset sequence.
module tb_hazard_fwd_unit;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_IALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] inst_d;
   logic        valid_d;
   logic        flush_x;
   logic        stall_d;
   logic [1:0]  asel_x, bsel_x, rs2sel_x;
   logic [4:0]  rd_w;
   logic        regwen_w;

   int n_cmp  = 0;
   int n_fail = 0;

   hazard_fwd_unit #(.REG_AW(5), .LOAD_STALL_CYCLES(1)) dut (
      .clk(clk), .rst_n(rst_n), .inst_d(inst_d), .valid_d(valid_d), .flush_x(flush_x),
      .stall_d(stall_d), .asel_x(asel_x), .bsel_x(bsel_x), .rs2sel_x(rs2sel_x),
      .rd_w(rd_w), .regwen_w(regwen_w)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic        vld;
      logic        fl;
      logic        stall;
      logic [1:0]  a;
      logic [1:0]  b;
      logic [1:0]  r2;
      logic [4:0]  rdw;
      logic        wen;
   } vec_t;

   vec_t tv[$];

   function automatic logic [31:0] enc(input logic [6:0] op, input int rd, input int rs1,
                                       input int rs2);
      return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), op};
   endfunction

   function automatic vec_t mk(input logic [31:0] inst, input logic vld, input logic fl,
                               input logic stall, input logic [1:0] a, input logic [1:0] b,
                               input logic [1:0] r2, input int rdw, input logic wen);
      vec_t v;
      v.inst = inst; v.vld = vld; v.fl = fl; v.stall = stall;
      v.a = a; v.b = b; v.r2 = r2; v.rdw = 5'(rdw); v.wen = wen;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   initial begin
      // row: inst, valid, flush, stall, asel, bsel, rs2sel (after edge), rd_w, regwen_w
      tv.push_back(mk(enc(OP_IALU, 1, 0, 5),  1, 0, 0, 2'b00, 2'b01, 2'b00, 0, 0)); // addi x1,x0,5
      tv.push_back(mk(enc(OP_R,    2, 1, 1),  1, 0, 0, 2'b10, 2'b10, 2'b00, 0, 0)); // add x2,x1,x1
      tv.push_back(mk(enc(OP_IALU, 1, 0, 1),  1, 0, 0, 2'b00, 2'b01, 2'b00, 1, 1)); // addi x1
      tv.push_back(mk(enc(OP_IALU, 0, 0, 0),  1, 0, 0, 2'b00, 2'b01, 2'b00, 2, 1)); // nop
      tv.push_back(mk(enc(OP_R,    3, 1, 4),  1, 0, 0, 2'b11, 2'b00, 2'b00, 1, 1)); // sub x3,x1,x4
      tv.push_back(mk(enc(OP_IALU, 5, 0, 1),  1, 0, 0, 2'b00, 2'b01, 2'b00, 0, 0)); // addi x5
      tv.push_back(mk(enc(OP_IALU, 5, 0, 2),  1, 0, 0, 2'b00, 2'b01, 2'b00, 3, 1)); // addi x5
      tv.push_back(mk(enc(OP_R,    6, 5, 5),  1, 0, 0, 2'b10, 2'b10, 2'b00, 5, 1)); // or x6,x5,x5
      tv.push_back(mk(enc(OP_LOAD, 7, 2, 0),  1, 0, 0, 2'b00, 2'b01, 2'b00, 5, 1)); // lw x7,0(x2)
      tv.push_back(mk(enc(OP_R,    8, 7, 0),  1, 0, 1, 2'b00, 2'b00, 2'b00, 6, 1)); // add stalls
      tv.push_back(mk(enc(OP_R,    8, 7, 0),  1, 0, 0, 2'b11, 2'b00, 2'b00, 7, 1)); // add re-eval
      tv.push_back(mk(enc(OP_IALU, 0, 0, 1),  1, 0, 0, 2'b00, 2'b01, 2'b00, 0, 0)); // addi x0,x0,1
      tv.push_back(mk(enc(OP_R,    9, 0, 0),  1, 0, 0, 2'b00, 2'b00, 2'b00, 8, 1)); // add x9,x0,x0
      tv.push_back(mk(enc(OP_R,    9, 9, 9),  0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0)); // invalid
      tv.push_back(mk(enc(OP_IALU, 1, 0, 3),  1, 0, 0, 2'b00, 2'b01, 2'b00, 9, 1)); // addi x1
      tv.push_back(mk(enc(OP_STORE,4, 2, 1),  1, 0, 0, 2'b00, 2'b01, 2'b10, 0, 0)); // sw x1,4(x2)
      tv.push_back(mk(enc(OP_BR,   0, 5, 1),  1, 0, 0, 2'b01, 2'b01, 2'b11, 1, 1)); // beq x5,x1
      tv.push_back(mk(enc(OP_LOAD,10, 1, 0),  1, 0, 0, 2'b00, 2'b01, 2'b00, 0, 0)); // lw x10
      tv.push_back(mk(enc(OP_R,   11,10,10),  1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0)); // flushed
      tv.push_back(mk(enc(OP_R,   11,10,10),  1, 0, 0, 2'b11, 2'b11, 2'b00,10, 1)); // add x11
      tv.push_back(mk(enc(OP_LUI, 12, 7, 0),  1, 0, 0, 2'b00, 2'b01, 2'b00, 0, 0)); // lui x12
      tv.push_back(mk(enc(OP_AUIPC,13,0, 0),  1, 0, 0, 2'b01, 2'b01, 2'b00,11, 1)); // auipc x13
      tv.push_back(mk(enc(OP_JALR,14,12, 0),  1, 0, 0, 2'b11, 2'b01, 2'b00,12, 1)); // jalr x14

      rst_n = 1'b0; inst_d = '0; valid_d = 1'b0; flush_x = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_asel", -1, 32'(asel_x), 0);
      chk("reset_bsel", -1, 32'(bsel_x), 0);
      chk("reset_rs2sel", -1, 32'(rs2sel_x), 0);
      chk("reset_rd_w", -1, 32'(rd_w), 0);
      chk("reset_regwen", -1, 32'(regwen_w), 0);
      chk("reset_stall", -1, 32'(stall_d), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tv.size(); i++) begin
         inst_d = tv[i].inst; valid_d = tv[i].vld; flush_x = tv[i].fl;
         #1;
         chk("stall_d", i, 32'(stall_d), 32'(tv[i].stall));
         @(posedge clk);
         #1;
         chk("asel_x", i, 32'(asel_x), 32'(tv[i].a));
         chk("bsel_x", i, 32'(bsel_x), 32'(tv[i].b));
         chk("rs2sel_x", i, 32'(rs2sel_x), 32'(tv[i].r2));
         chk("rd_w", i, 32'(rd_w), 32'(tv[i].rdw));
         chk("regwen_w", i, 32'(regwen_w), 32'(tv[i].wen));
      end

      // Mid-stream reset with a load in X and its consumer in D.
      inst_d = enc(OP_LOAD, 7, 2, 0); valid_d = 1'b1; flush_x = 1'b0;
      @(posedge clk); #1;
      inst_d = enc(OP_LOAD, 7, 2, 0);
      @(posedge clk); #1;
      inst_d = enc(OP_R, 8, 7, 7);
      #1;
      chk("mid_stall_before", 100, 32'(stall_d), 1);
      chk("mid_regwen_before", 100, 32'(regwen_w), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_stall", 101, 32'(stall_d), 0);
      chk("mid_rst_asel", 101, 32'(asel_x), 0);
      chk("mid_rst_bsel", 101, 32'(bsel_x), 0);
      chk("mid_rst_rs2sel", 101, 32'(rs2sel_x), 0);
      chk("mid_rst_regwen", 101, 32'(regwen_w), 0);
      chk("mid_rst_rd_w", 101, 32'(rd_w), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_stall", 102, 32'(stall_d), 0);
      @(posedge clk); #1;
      chk("post_rst_asel", 102, 32'(asel_x), 0);
      chk("post_rst_bsel", 102, 32'(bsel_x), 0);
      chk("post_rst_regwen", 102, 32'(regwen_w), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
